// File: rtl/pong_score_keeper.sv
// Score keeper for Pong: edge-detects point/new-game inputs, keeps BCD scores per player,
// sequences a post-point serve hold, and flags the winner once WIN_SCORE is reached.
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE     = 11,
  parameter int unsigned SERVE_DELAY   = 50000000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       new_game,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic       serve_ready,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned CntW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SERVE_DELAY - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = '0;
  localparam logic [3:0] WinTens   = 4'(WIN_SCORE / 10);
  localparam logic [3:0] WinOnes   = 4'(WIN_SCORE % 10);
  localparam logic [7:0] WinScore  = {WinTens, WinOnes};
  localparam logic [3:0] BlankCode = BLANK_LEADING ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    StPlay,
    StHold,
    StOver
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            p1_prev_q, p2_prev_q, ng_prev_q;
  logic [7:0]      p1_score_q, p1_score_d;
  logic [7:0]      p2_score_q, p2_score_d;
  logic            serve_ready_q, serve_ready_d;
  logic            game_over_q, game_over_d;
  logic [1:0]      winner_q, winner_d;
  logic [3:0]      p1_tens_q, p1_tens_d;
  logic [3:0]      p1_ones_q, p1_ones_d;
  logic [3:0]      p2_tens_q, p2_tens_d;
  logic [3:0]      p2_ones_q, p2_ones_d;

  logic p1_evt, p2_evt, ng_evt;

  assign p1_evt = p1_point & ~p1_prev_q;
  assign p2_evt = p2_point & ~p2_prev_q;
  assign ng_evt = new_game & ~ng_prev_q;

  // Score is {tens, ones} in BCD; ones rolls 9->0 with carry into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [3:0] t;
    logic [3:0] o;
    t = s[7:4];
    o = s[3:0];
    if (o == 4'd9) begin
      t = t + 4'd1;
      o = 4'd0;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  function automatic logic [3:0] tens_disp(input logic [3:0] t);
    return (t == 4'd0) ? BlankCode : t;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    serve_ready_d = serve_ready_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;

    if (ng_evt) begin
      p1_score_d    = 8'h00;
      p2_score_d    = 8'h00;
      winner_d      = 2'b00;
      game_over_d   = 1'b0;
      serve_ready_d = 1'b0;
      cnt_d         = CntLoad;
      state_d       = StHold;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (p1_evt || p2_evt) begin
            // Player 1 wins a tie; a simultaneous p2 event is dropped.
            if (p1_evt) begin
              p1_score_d = bcd_inc(p1_score_q);
            end else begin
              p2_score_d = bcd_inc(p2_score_q);
            end
            serve_ready_d = 1'b0;
            if ((p1_evt && p1_score_d == WinScore) || (!p1_evt && p2_score_d == WinScore)) begin
              state_d     = StOver;
              game_over_d = 1'b1;
              winner_d    = p1_evt ? 2'b01 : 2'b10;
            end else begin
              state_d = StHold;
              cnt_d   = CntLoad;
            end
          end
        end
        StHold: begin
          if (cnt_q == CntZero) begin
            state_d       = StPlay;
            serve_ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StOver: begin
        end
        default: begin
          state_d = StPlay;
        end
      endcase
    end

    p1_tens_d = tens_disp(p1_score_d[7:4]);
    p1_ones_d = p1_score_d[3:0];
    p2_tens_d = tens_disp(p2_score_d[7:4]);
    p2_ones_d = p2_score_d[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StPlay;
      cnt_q         <= CntZero;
      p1_prev_q     <= 1'b0;
      p2_prev_q     <= 1'b0;
      ng_prev_q     <= 1'b0;
      p1_score_q    <= 8'h00;
      p2_score_q    <= 8'h00;
      serve_ready_q <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
      p1_tens_q     <= BlankCode;
      p1_ones_q     <= 4'd0;
      p2_tens_q     <= BlankCode;
      p2_ones_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p1_prev_q     <= p1_point;
      p2_prev_q     <= p2_point;
      ng_prev_q     <= new_game;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      serve_ready_q <= serve_ready_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      p1_tens_q     <= p1_tens_d;
      p1_ones_q     <= p1_ones_d;
      p2_tens_q     <= p2_tens_d;
      p2_ones_q     <= p2_ones_d;
    end
  end

  assign p1_tens     = p1_tens_q;
  assign p1_ones     = p1_ones_q;
  assign p2_tens     = p2_tens_q;
  assign p2_ones     = p2_ones_q;
  assign serve_ready = serve_ready_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: directed scenarios plus random play, scoreboarded against an
// integer-score reference model; a second instance covers the unblanked tens digit.
module tb_pong_score_keeper;

  localparam int unsigned Win = 11;
  localparam int unsigned Dly = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic p1_point = 1'b0;
  logic p2_point = 1'b0;
  logic new_game = 1'b0;

  logic [3:0] a_p1t, a_p1o, a_p2t, a_p2o;
  logic       a_sr, a_go;
  logic [1:0] a_win;
  logic [3:0] b_p1t, b_p1o, b_p2t, b_p2o;
  logic       b_sr, b_go;
  logic [1:0] b_win;

  always #5 clk = ~clk;

  pong_score_keeper #(.WIN_SCORE(Win), .SERVE_DELAY(Dly), .BLANK_LEADING(1'b1)) u_blank (
    .clk(clk), .reset(reset), .p1_point(p1_point), .p2_point(p2_point), .new_game(new_game),
    .p1_tens(a_p1t), .p1_ones(a_p1o), .p2_tens(a_p2t), .p2_ones(a_p2o),
    .serve_ready(a_sr), .game_over(a_go), .winner(a_win)
  );

  pong_score_keeper #(.WIN_SCORE(Win), .SERVE_DELAY(Dly), .BLANK_LEADING(1'b0)) u_zero (
    .clk(clk), .reset(reset), .p1_point(p1_point), .p2_point(p2_point), .new_game(new_game),
    .p1_tens(b_p1t), .p1_ones(b_p1o), .p2_tens(b_p2t), .p2_ones(b_p2o),
    .serve_ready(b_sr), .game_over(b_go), .winner(b_win)
  );

  typedef struct packed {
    logic [3:0] p1t, p1o, p2t, p2o;
    logic       sr, go;
    logic [1:0] win;
    logic [3:0] p1t0, p2t0;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model: plain integer scores and a count of remaining no-serve cycles.
  int s1, s2, win_who, low_left;
  bit over, pr1, pr2, prn;

  function automatic logic [3:0] tens_of(input int s, input bit blank);
    if (s / 10 == 0 && blank) return 4'hF;
    return 4'(s / 10);
  endfunction

  task automatic model_step();
    bit e1, e2, en;
    exp_t e;
    if (reset) begin
      s1 = 0; s2 = 0; win_who = 0; low_left = 0; over = 0;
      pr1 = 0; pr2 = 0; prn = 0;
    end else begin
      e1 = p1_point && !pr1;
      e2 = p2_point && !pr2;
      en = new_game && !prn;
      pr1 = p1_point; pr2 = p2_point; prn = new_game;
      if (en) begin
        s1 = 0; s2 = 0; win_who = 0; over = 0; low_left = Dly;
      end else if (over) begin
      end else if (low_left > 0) begin
        low_left--;
      end else if (e1) begin
        s1++;
        if (s1 == Win) begin over = 1; win_who = 1; end
        else low_left = Dly;
      end else if (e2) begin
        s2++;
        if (s2 == Win) begin over = 1; win_who = 2; end
        else low_left = Dly;
      end
    end
    e.p1t  = tens_of(s1, 1'b1);
    e.p1o  = 4'(s1 % 10);
    e.p2t  = tens_of(s2, 1'b1);
    e.p2o  = 4'(s2 % 10);
    e.sr   = !over && low_left == 0;
    e.go   = over;
    e.win  = 2'(win_who);
    e.p1t0 = tens_of(s1, 1'b0);
    e.p2t0 = tens_of(s2, 1'b0);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic a, input logic b, input logic n);
    @(negedge clk);
    reset = r; p1_point = a; p2_point = b; new_game = n;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every clock presents a full output vector; compare it with the oldest expectation.
  exp_t mon_e, mon_a;
  always @(posedge clk) begin
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {a_p1t, a_p1o, a_p2t, a_p2o, a_sr, a_go, a_win, b_p1t, b_p2t};
      checks++;
      if (mon_a !== mon_e ||
          {b_p1o, b_p2o, b_sr, b_go, b_win} !== {mon_e.p1o, mon_e.p2o, mon_e.sr, mon_e.go, mon_e.win})
      begin
        errors++;
        $display("FAIL outputs@cycle%0d got p1=%h%h p2=%h%h sr=%b go=%b win=%b z_tens=%h/%h z_rest=%h%h%b%b%b exp p1=%h%h p2=%h%h sr=%b go=%b win=%b z_tens=%h/%h",
                 cycle, a_p1t, a_p1o, a_p2t, a_p2o, a_sr, a_go, a_win, b_p1t, b_p2t,
                 b_p1o, b_p2o, b_sr, b_go, b_win,
                 mon_e.p1t, mon_e.p1o, mon_e.p2t, mon_e.p2o, mon_e.sr, mon_e.go, mon_e.win,
                 mon_e.p1t0, mon_e.p2t0);
      end
    end
  end

  initial begin
    // 1: reset then a single p1 pulse and the serve hold.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(7);
    // 2: p2 held high for 20 cycles, then a pulse during hold.
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    // 3: p1 climbs to 10 (9->10 carry; score 5 seen on the unblanked instance).
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      idle(Dly + 1);
    end
    // 4: winning point, then ignored pulses.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    // 5: new game, simultaneous p1/p2, then new_game with p1.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(Dly + 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    idle(Dly + 1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    idle(Dly + 2);
    // 6: reset mid-hold when the counter reads 2, then an immediate point.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(Dly + 2);
    // Random play with held levels, occasional new games and resets.
    for (int i = 0; i < 3000; i++) begin
      logic r, a, b, n;
      a = p1_point; b = p2_point; n = new_game;
      if ($urandom_range(5) == 0) a = ~a;
      if ($urandom_range(5) == 0) b = ~b;
      if ($urandom_range(40) == 0) n = ~n;
      r = ($urandom_range(250) == 0);
      drive(r, a, b, n);
    end
    idle(3);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
- Holds both players' scores for the Pong game.
- Converts each score into two BCD digits (tens, ones) that drive the four per-digit 7-segment decoders directly.
- Sits between the ball/collision logic, which supplies point events, and the hex display decoders.
- Sequences play through a post-point serve hold and end-of-game detection.

Parameters:
- WIN_SCORE, 11, score that ends the game; legal range 1..99.
- SERVE_DELAY, 50000000, number of clk cycles serve_ready stays low after a point (1 s at 50 MHz); legal range ≥1.
- BLANK_LEADING, 1, when 1 a tens digit of 0 is output as 4'hF (blank code for the decoder); when 0 it is output as 4'h0.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- p1_point  input  1  level from ball logic; rising edge = player 1 scored
- p2_point  input  1  level from ball logic; rising edge = player 2 scored
- new_game  input  1  rising edge = clear scores and start a new game
- p1_tens  output  4  player 1 tens digit, BCD or 4'hF
- p1_ones  output  4  player 1 ones digit, BCD 0..9
- p2_tens  output  4  player 2 tens digit, BCD or 4'hF
- p2_ones  output  4  player 2 ones digit, BCD 0..9
- serve_ready  output  1  high when ball logic may serve or keep playing
- game_over  output  1  high once a player reaches WIN_SCORE
- winner  output  2  00 none, 01 player 1, 10 player 2

Behaviour:
- Reset values:
  - scores 0; state PLAY; edge-detect registers 0; hold counter 0.
  - serve_ready=1, game_over=0, winner=00.
  - ones digits 0.
  - tens digits 4'hF if BLANK_LEADING=1, else 0.
- Edge detection:
  - Each input is compared with its registered value from the previous cycle; an event is input=1 and previous=0.
  - An input held high produces exactly one event.
  - After reset the previous-value registers are 0, so an input already high at reset release produces one event.
- Scores:
  - Stored internally as BCD digit pairs.
  - An increment adds 1 to ones; on 9→0, tens increments.
  - All outputs are registered; a score changes on the clock edge that detects the event and is visible in the following cycle (1-cycle latency).
- States:
  - PLAY:
    - p1 event → p1 score +1.
    - Else p2 event → p2 score +1. Player 1 has priority; a simultaneous p2 event is dropped.
    - After an increment: if the new score == WIN_SCORE, go to OVER and set winner (01 or 10), game_over=1, serve_ready=0.
    - Otherwise go to HOLD, load the counter with SERVE_DELAY-1, and set serve_ready=0.
  - HOLD:
    - Point events are ignored.
    - The counter decrements each cycle. When it is 0, go to PLAY with serve_ready=1.
    - serve_ready is low for exactly SERVE_DELAY cycles.
  - OVER:
    - Point events are ignored; scores and winner are frozen.
- new_game event, in any state:
  - Highest priority over point events in the same cycle.
  - Scores cleared, winner=00, game_over=0.
  - Go to HOLD with the counter = SERVE_DELAY-1 and serve_ready=0.
- Reset wins over everything, including mid-HOLD; it goes straight to PLAY with serve_ready=1.
- Scores never exceed WIN_SCORE, so no 99→0 wrap is reachable.
- The hold counter width is sized from SERVE_DELAY and never underflows.

Test Plan:
1. WIN_SCORE=11, SERVE_DELAY=4: reset, then a single p1_point pulse → next cycle p1_tens=F, p1_ones=1, serve_ready=0 for exactly 4 cycles, then 1.
2. Hold p2_point high for 20 cycles in PLAY → p2 score 1 only. Pulse p2_point during HOLD → ignored, score stays 1.
3. Ten p1 points, each after serve_ready returns → p1_tens=1, p1_ones=0 (9→10 carry). With BLANK_LEADING=0, score 5 shows tens=0, ones=5.
4. p1 at 10, then p1 point → p1=11, game_over=1, winner=01, serve_ready=0. Further p1/p2 pulses leave all outputs unchanged.
5. p1_point and p2_point rise in the same PLAY cycle → only p1 increments. new_game and p1_point together → scores 00/00 (tens F), HOLD entered, winner=00.
6. Reset asserted mid-HOLD at counter=2 → next cycle serve_ready=1, scores cleared, state PLAY; the next point is accepted immediately.
